mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences and shares the single unified instruction/data memory between the multicycle CPU control path and the debug/loader port. Each access is a request/ready handshake. The arbiter runs one memory transaction at a time with round-robin fairness, and a debug hold lets the loader take exclusive ownership. It sits between the CPU datapath's memory address mux (IorD path) and the memory macro.

## Interface
- ADDR_W, 8: word-address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: memory read latency in cycles, from address registered to `mem_rdata` valid; must be ≥1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request; level, held until `cpu_ready`.
- cpu_we  in  1  CPU write enable; stable while `cpu_req`.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; registered, held until the next CPU read completes.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug-port equivalents of the CPU inputs.
- dbg_rdata  out  DATA_W  debug-port read data.
- dbg_ready  out  1  debug-port completion pulse.
- dbg_hold  in  1  while high, `cpu_req` is masked from arbitration.
- mem_addr  out  ADDR_W  registered memory address.
- mem_we  out  1  registered memory write strobe.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state ≠ IDLE.
- owner  out  1  0 = CPU, 1 = debug; holds the owner of the current or last grant.

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: address, write strobe and write data on the memory bus.
  - WAIT: count down the latency.
  - DONE: ready pulse.
- Effective requests: `c = cpu_req & ~dbg_hold`, `d = dbg_req`.
- Transitions out of IDLE:
  - Only c: go to ACCESS, grant CPU.
  - Only d: go to ACCESS, grant debug.
  - Both c and d: grant the port that is not `last`, then go to ACCESS.
  - Neither: stay in IDLE.
- `last` holds the most recently granted port and updates on each grant. It resets to debug, so the CPU wins the first tie.
- On entry to ACCESS, register the granted port's address, write enable and write data into `mem_addr`, `mem_we` and `mem_wdata`, and load the counter with MEM_LAT−1.
- ACCESS always goes to WAIT.
- WAIT:
  - Stays in WAIT while the counter is nonzero, decrementing it each cycle.
  - When the counter is 0, capture `mem_rdata` into the owner's rdata register (reads only; writes leave it unchanged) and go to DONE.
- DONE: assert the owner's ready for one cycle, then go to IDLE unconditionally.
- `mem_we` is high only in the ACCESS cycle. `mem_addr` and `mem_wdata` hold their values until the next grant.
- Requests seen in DONE are ignored. The served requester must drop `req` in its ready cycle.
- A request deasserted during ACCESS, WAIT or DONE does not cancel the transaction. The memory access and the ready pulse still occur.
- A change to `dbg_hold` while the CPU owns a transaction does not abort it. The hold only affects the next arbitration.
- Counter width is clog2(MEM_LAT+1). It never wraps below 0.

## Timing
- Reset values: state IDLE, `last` = 1, and every output 0 (`mem_addr`, `mem_we`, `mem_wdata`, `cpu_rdata`, `dbg_rdata`, `cpu_ready`, `dbg_ready`, `busy`, `owner`).
- Asserting `rst_n` low mid-transaction clears everything immediately:
  - `mem_we` drops asynchronously.
  - No ready pulse is issued.
- Take cycle 0 as the cycle in which a request is seen in IDLE:
  - Cycle 1: ACCESS, bus driven, `busy` = 1.
  - Cycles 2 … 1+MEM_LAT: WAIT.
  - Cycle 2+MEM_LAT: DONE, ready = 1 and rdata valid.
  - Cycle 3+MEM_LAT: IDLE.
- With MEM_LAT = 1: ready occurs 3 cycles after request, and one access completes every 4 cycles.
- `cpu_ready` and `dbg_ready` are never high in the same cycle.
- A losing requester waits at most one full transaction (4 cycles at MEM_LAT = 1) plus its own.

## Test plan
- Reset, then CPU read of address 0x05 (memory holds 0xDEADBEEF), MEM_LAT = 1 -> `mem_addr` = 0x05 in cycle 1, `cpu_ready` pulses in cycle 3 with `cpu_rdata` = 0xDEADBEEF, `busy` low in cycle 4.
- Debug write of 0x12345678 to 0x10, then CPU read of 0x10 -> `mem_we` high exactly one cycle, `dbg_ready` pulse, then `cpu_rdata` = 0x12345678.
- `cpu_req` and `dbg_req` both held continuously, each dropped in its ready cycle and reasserted next cycle -> grants alternate CPU, DBG, CPU, DBG; first grant is CPU.
- `dbg_hold` = 1 with `cpu_req` held -> no CPU grant and `busy` stays 0. Release `dbg_hold` -> `cpu_ready` 3 cycles after the IDLE cycle in which the CPU request is first seen.
- `rst_n` pulsed low during ACCESS of a CPU write -> `mem_we` 0 immediately, no `cpu_ready`, state IDLE, rdata registers 0.
- MEM_LAT = 3, CPU read -> `cpu_ready` exactly 5 cycles after the request cycle, and rdata is sampled from `mem_rdata` in the last WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if
// CPU, debug and memory-side signals of the shared memory port arbiter.
// Revision: 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ready;
    logic              dbg_hold;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;

    // Requesters and memory macro side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_hold,
        input  dbg_rdata, dbg_ready,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_hold,
        output dbg_rdata, dbg_ready,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
// Round-robin sharing of one unified memory between CPU and debug/loader port.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int                 c_CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic                r_owner;
    logic                r_is_write;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_c;
    logic                w_d;
    logic                w_grant;
    logic                w_grant_dbg;

    always_comb begin
        w_c         = bus.cpu_req & ~bus.dbg_hold;
        w_d         = bus.dbg_req;
        w_grant     = 1'b0;
        w_grant_dbg = 1'b0;
        w_next      = r_state;
        case (r_state)
            S_IDLE: begin
                // On a tie the port not served most recently wins
                if (w_c && w_d) begin
                    w_grant     = 1'b1;
                    w_grant_dbg = ~r_last;
                end else if (w_c) begin
                    w_grant     = 1'b1;
                    w_grant_dbg = 1'b0;
                end else if (w_d) begin
                    w_grant     = 1'b1;
                    w_grant_dbg = 1'b1;
                end
                if (w_grant) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_WAIT;
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_is_write  <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state  <= w_next;
            r_mem_we <= 1'b0;
            if (w_grant) begin
                r_last      <= w_grant_dbg;
                r_owner     <= w_grant_dbg;
                r_cnt       <= c_CNT_LOAD;
                r_mem_addr  <= w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                r_mem_we    <= w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
                r_is_write  <= w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
                r_mem_wdata <= w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            end
            if (r_state == S_WAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else if (!r_is_write) begin
                    if (r_owner) begin
                        r_dbg_rdata <= bus.mem_rdata;
                    end else begin
                        r_cpu_rdata <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.cpu_ready = (r_state == S_DONE) && !r_owner;
    assign bus.dbg_ready = (r_state == S_DONE) &&  r_owner;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.owner     = r_owner;
endmodule
`default_nettype wire
